// File: rtl/clock_select_ctrl.sv
// -----------------------------------------------------------------------------
// clock_select_ctrl
//
// Purpose:
//   Sequences the select lines of a downstream glitch-free clock mux. A
//   switch first drops every select bit for a drain period, then raises
//   the new select and waits a settle period before acknowledging. With
//   AUTO_FAILOVER enabled, a dead active clock triggers an autonomous
//   switch to the lowest-index clock that is still alive.
//
// Ports:
//   clk         in   system clock; all logic on its rising edge
//   rst         in   synchronous active-high reset
//   req_valid   in   one-cycle switch request strobe
//   req_sel     in   requested clock index, sampled with req_valid
//   clk_alive   in   per-clock activity flags, already synchronised to clk
//   clk_select  out  one-hot or all-zero mux select (registered)
//   cur_sel     out  index of the current / most recent clock (registered)
//   busy        out  high while a switch is in progress (registered)
//   ack         out  one-cycle pulse on switch completion (registered)
//   err         out  one-cycle pulse on a rejected request (registered)
// -----------------------------------------------------------------------------
module clock_select_ctrl #(
    parameter int NUM_CLOCKS    = 4,
    parameter int SEL_BITS      = 2,
    parameter int DRAIN_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 8,
    parameter int DEFAULT_SEL   = 0,
    parameter int AUTO_FAILOVER = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [SEL_BITS-1:0]   req_sel,
    input  logic [NUM_CLOCKS-1:0] clk_alive,
    output logic [NUM_CLOCKS-1:0] clk_select,
    output logic [SEL_BITS-1:0]   cur_sel,
    output logic                  busy,
    output logic                  ack,
    output logic                  err
);

    // Full index space of req_sel / cur_sel; may exceed NUM_CLOCKS.
    localparam int PAD_CLOCKS = 1 << SEL_BITS;

    // Counters count down from N-1 to 0, so the state lasts exactly N cycles.
    localparam logic [7:0] DRAIN_LOAD  = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    localparam logic [SEL_BITS:0]     NUM_CLOCKS_W = (SEL_BITS + 1)'(NUM_CLOCKS);
    localparam logic [NUM_CLOCKS-1:0] ONE_SEL      = NUM_CLOCKS'(1);
    localparam logic [NUM_CLOCKS-1:0] RESET_SELECT = ONE_SEL << DEFAULT_SEL;
    localparam logic [SEL_BITS-1:0]   RESET_INDEX  = SEL_BITS'(DEFAULT_SEL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t                state_reg;
    logic [7:0]            drain_cnt_reg;
    logic [7:0]            settle_cnt_reg;
    logic [SEL_BITS-1:0]   target_reg;
    logic [SEL_BITS-1:0]   cur_sel_reg;
    logic [NUM_CLOCKS-1:0] clk_select_reg;
    logic                  busy_reg;
    logic                  ack_reg;
    logic                  err_reg;

    // -------------------------------------------------------------------------
    // clk_alive widened to the whole index space. Indices at or beyond
    // NUM_CLOCKS read as dead, so an out-of-range index can never look usable
    // and never indexes past the real vector.
    // -------------------------------------------------------------------------
    logic [PAD_CLOCKS-1:0] alive_pad;

    generate
        for (genvar gi = 0; gi < PAD_CLOCKS; gi++) begin : g_alive_pad
            if (gi < NUM_CLOCKS) begin : g_real
                assign alive_pad[gi] = clk_alive[gi];
            end else begin : g_unused
                assign alive_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Lowest-index alive clock: the loop runs high to low so the last hit
    // (lowest index) wins.
    logic [SEL_BITS-1:0] failover_sel;

    always_comb begin
        failover_sel = '0;
        for (int i = NUM_CLOCKS - 1; i >= 0; i--) begin
            if (clk_alive[i]) begin
                failover_sel = SEL_BITS'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // IDLE decision logic
    // -------------------------------------------------------------------------
    logic any_alive;
    logic cur_alive;
    logic req_in_range;
    logic req_usable;
    logic failover_go;
    logic start_switch;
    logic [SEL_BITS-1:0] start_target;
    logic req_same_ack;
    logic req_reject;

    assign any_alive    = |clk_alive;
    assign cur_alive    = alive_pad[cur_sel_reg];
    assign req_in_range = {1'b0, req_sel} < NUM_CLOCKS_W;
    assign req_usable   = req_in_range && alive_pad[req_sel];

    // The active clock is dead while another one lives. This takes priority
    // over any request issued in the same cycle; that request is dropped.
    assign failover_go = (AUTO_FAILOVER != 0) && (state_reg == ST_IDLE)
                         && !cur_alive && any_alive;

    always_comb begin
        start_switch = 1'b0;
        start_target = req_sel;
        req_same_ack = 1'b0;
        req_reject   = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (failover_go) begin
                start_switch = 1'b1;
                start_target = failover_sel;
            end else if (any_alive && req_valid) begin
                // With no clock alive at all the block stays quiet, so
                // requests are only evaluated while something is running.
                if (!req_usable) begin
                    req_reject = 1'b1;
                end else if (req_sel == cur_sel_reg) begin
                    req_same_ack = 1'b1;
                end else begin
                    start_switch = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer. Every output is a register; ack/err default low so they
    // pulse for exactly one cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            drain_cnt_reg  <= 8'd0;
            settle_cnt_reg <= 8'd0;
            target_reg     <= RESET_INDEX;
            cur_sel_reg    <= RESET_INDEX;
            clk_select_reg <= RESET_SELECT;
            busy_reg       <= 1'b0;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_switch) begin
                        // Break the old select before anything new is driven.
                        state_reg      <= ST_DRAIN;
                        drain_cnt_reg  <= DRAIN_LOAD;
                        target_reg     <= start_target;
                        clk_select_reg <= '0;
                        busy_reg       <= 1'b1;
                    end else if (req_same_ack) begin
                        ack_reg <= 1'b1;
                    end else if (req_reject) begin
                        err_reg <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    // clk_alive changes are deliberately ignored here; the
                    // switch always runs to completion.
                    if (drain_cnt_reg == 8'd0) begin
                        state_reg      <= ST_SETTLE;
                        settle_cnt_reg <= SETTLE_LOAD;
                        clk_select_reg <= ONE_SEL << target_reg;
                        cur_sel_reg    <= target_reg;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 8'd1;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt_reg == 8'd0) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        ack_reg   <= 1'b1;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 8'd1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a safe idle state
                    // holding the last committed selection.
                    state_reg      <= ST_IDLE;
                    busy_reg       <= 1'b0;
                    clk_select_reg <= ONE_SEL << cur_sel_reg;
                end
            endcase
        end
    end

    assign clk_select = clk_select_reg;
    assign cur_sel    = cur_sel_reg;
    assign busy       = busy_reg;
    assign ack        = ack_reg;
    assign err        = err_reg;

endmodule

// File: doc/clock_select_ctrl.md
CLOCK_SELECT_CTRL -- requirements
Module: clock_select_ctrl

Interface
REQ-001 Parameter NUM_CLOCKS, default 4, SHALL set the number of selectable clocks (2..16).
REQ-002 Parameter SEL_BITS, default 2, SHALL set the width of the index ports, with 2**SEL_BITS >= NUM_CLOCKS.
REQ-003 Parameter DRAIN_CYCLES, default 8, SHALL set the cycles clk_select is held all-zero during a switch (1..255).
REQ-004 Parameter SETTLE_CYCLES, default 8, SHALL set the cycles after the new select asserts before ack (1..255).
REQ-005 Parameter DEFAULT_SEL, default 0, SHALL set the clock index selected out of reset.
REQ-006 Parameter AUTO_FAILOVER, default 1, SHALL enable autonomous switching away from a dead clock.
REQ-007 clk  input  1  free-running system clock; the design has one clock, and all logic SHALL be on its rising edge.
REQ-008 rst  input  1  reset; synchronous and active-high.
REQ-009 req_valid  input  1  one-cycle switch request strobe.
REQ-010 req_sel  input  SEL_BITS  requested clock index, sampled with req_valid.
REQ-011 clk_alive  input  NUM_CLOCKS  per-clock activity flags, already synchronised to clk.
REQ-012 clk_select  output  NUM_CLOCKS  one-hot or all-zero select to the downstream glitch-free clock mux; registered.
REQ-013 cur_sel  output  SEL_BITS  index of the currently or most recently selected clock; registered.
REQ-014 busy  output  1  high while a switch is in progress.
REQ-015 ack  output  1  one-cycle pulse on switch completion.
REQ-016 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-017 The FSM SHALL have states IDLE, DRAIN and SETTLE, with IDLE being the only state that accepts requests.
REQ-018 clk_select SHALL never have more than one bit set in any cycle.
REQ-019 A request is accepted in cycle T when the state is IDLE, req_valid=1, req_sel<NUM_CLOCKS, req_sel!=cur_sel and clk_alive[req_sel]=1.
REQ-020 On acceptance, for T+1..T+DRAIN_CYCLES: clk_select=0, busy=1, state DRAIN.
REQ-021 From T+DRAIN_CYCLES+1: clk_select=1<<req_sel and cur_sel=req_sel (same cycle), busy=1, state SETTLE for SETTLE_CYCLES cycles.
REQ-022 At T+DRAIN_CYCLES+SETTLE_CYCLES+1: ack=1, busy=0, state IDLE; a valid request in this cycle SHALL be accepted.
REQ-023 A request in IDLE with req_sel==cur_sel and clk_alive[req_sel]=1 SHALL give ack=1 at T+1 with no change to clk_select and busy staying 0.
REQ-024 A request in IDLE with req_sel>=NUM_CLOCKS or clk_alive[req_sel]=0 SHALL give err=1 at T+1 with no other output change.
REQ-025 req_valid while busy=1 SHALL be ignored: no ack, no err, no queueing.
REQ-026 With AUTO_FAILOVER=1 in IDLE, if clk_alive[cur_sel]=0 and any other bit of clk_alive is 1, the FSM SHALL start a switch to the lowest-index alive clock with the same timing as REQ-020..022, including ack.
REQ-027 If failover and req_valid occur in the same cycle, failover SHALL win and the request SHALL be dropped silently.
REQ-028 If no clock is alive, the FSM SHALL remain in IDLE, keep clk_select unchanged and pulse neither ack nor err.
REQ-029 Changes to clk_alive during DRAIN or SETTLE SHALL NOT abort the switch; the condition is re-evaluated on return to IDLE.
REQ-030 The DRAIN and SETTLE counters SHALL be 8 bits wide, load on state entry, and never wrap.

Reset
REQ-031 While rst=1 at a clk edge, the block SHALL set clk_select=1<<DEFAULT_SEL, cur_sel=DEFAULT_SEL, busy=0, ack=0, err=0, state=IDLE and counters=0.
REQ-032 rst asserted mid-switch SHALL abandon the switch in the next cycle with no ack and no err pulse.
REQ-033 In the first cycle after rst deasserts, inputs SHALL be evaluated normally, including failover.

Verification
REQ-034 Reset, then req_sel=2 with all clocks alive -> clk_select=0 for cycles T+1..T+8, 4'b0100 from T+9, ack at T+17, busy high T+1..T+16.
REQ-035 req_sel=cur_sel -> ack at T+1, clk_select unchanged, busy stays 0; req_sel=3 with clk_alive[3]=0 -> err at T+1 only.
REQ-036 cur_sel=0, clk_alive drops to 4'b1010 -> switch to index 1 with full drain/settle timing and ack; later clk_alive=0 -> no activity.
REQ-037 Second request at T+5 during a switch -> ignored, target unchanged, single ack at T+17.
REQ-038 rst pulse at T+10 mid-switch -> clk_select=4'b0001 and busy=0 next cycle, no ack; a one-hot assertion checked every cycle SHALL never fire.
